// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size encodings and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Core-request and data-memory signals of the load/store unit.
// master = environment (core + memory), slave = load_store_unit.
interface load_store_unit_if;

  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misaligned;
  logic        illegal;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  rdata, stall, misaligned, illegal, mem_re, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output rdata, stall, misaligned, illegal, mem_re, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_lane.sv
// Combinational byte/halfword lane logic: load extract+extend and store merge.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] load_word,
  input  logic [31:0] store_old,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = load_word[7:0];
      2'd1:    byte_sel = load_word[15:8];
      2'd2:    byte_sel = load_word[23:16];
      default: byte_sel = load_word[31:24];
    endcase
    half_sel = addr_lo[1] ? load_word[31:16] : load_word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = load_word;
    endcase
  end

  always_comb begin
    store_word = store_old;
    case (funct3)
      F3_B: begin
        case (addr_lo)
          2'd0:    store_word[7:0]   = store_data[7:0];
          2'd1:    store_word[15:8]  = store_data[7:0];
          2'd2:    store_word[23:16] = store_data[7:0];
          default: store_word[31:24] = store_data[7:0];
        endcase
      end
      F3_H: begin
        if (addr_lo[1]) store_word[31:16] = store_data[15:0];
        else            store_word[15:0]  = store_data[15:0];
      end
      default: store_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: fault decode, memory strobe muxing and the sub-word
// read-modify-write FSM (IDLE reads and merges, WRITE commits the merged word).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_AW = 6
) (
  input  logic                clk,
  input  logic                reset,
  load_store_unit_if.slave    bus
);

  if (MEM_AW < 1 || MEM_AW > 30) begin : g_aw_check
    $error("load_store_unit: MEM_AW out of range");
  end

  lsu_state_t  state;
  logic [31:0] wr_word;
  logic [31:0] wr_addr;
  logic [31:0] aligned_addr;
  logic [31:0] lane_rdata;
  logic [31:0] merged_word;
  logic        fault_ill;
  logic        fault_mis;
  logic        rmw_start;

  assign aligned_addr = {bus.req_addr[31:2], 2'b00};

  lsu_lane u_lane (
    .addr_lo    (bus.req_addr[1:0]),
    .funct3     (bus.req_funct3),
    .load_word  (bus.mem_rdata),
    .store_old  (bus.mem_rdata),
    .store_data (bus.req_wdata),
    .load_data  (lane_rdata),
    .store_word (merged_word)
  );

  always_comb begin
    if (bus.req_we)
      fault_ill = bus.req_funct3[2] || (bus.req_funct3 == 3'b011);
    else
      fault_ill = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);

    case (bus.req_funct3[1:0])
      2'b01:   fault_mis = bus.req_addr[0];
      2'b10:   fault_mis = |bus.req_addr[1:0];
      default: fault_mis = 1'b0;
    endcase
  end

  always_comb begin
    bus.stall      = 1'b0;
    bus.misaligned = 1'b0;
    bus.illegal    = 1'b0;
    bus.mem_re     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.rdata      = '0;
    rmw_start      = 1'b0;

    // Reset blanks every output; WRITE ignores the request entirely.
    if (!reset) begin
      if (state == WRITE) begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = wr_addr;
        bus.mem_wdata = wr_word;
      end else if (bus.req_valid) begin
        if (fault_ill) begin
          bus.illegal = 1'b1;
        end else if (fault_mis) begin
          bus.misaligned = 1'b1;
        end else if (!bus.req_we) begin
          bus.mem_re   = 1'b1;
          bus.mem_addr = aligned_addr;
          bus.rdata    = lane_rdata;
        end else if (bus.req_funct3 == F3_W) begin
          bus.mem_we    = 1'b1;
          bus.mem_addr  = aligned_addr;
          bus.mem_wdata = bus.req_wdata;
        end else begin
          bus.mem_re   = 1'b1;
          bus.mem_addr = aligned_addr;
          bus.stall    = 1'b1;
          rmw_start    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wr_word <= '0;
      wr_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rmw_start) begin
            wr_word <= merged_word;
            wr_addr <= aligned_addr;
            state   <= WRITE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed test-plan sequence followed
// by randomized traffic, both checked every cycle against a request-level model.
module tb_load_store_unit;

  localparam int unsigned AW    = 6;
  localparam int unsigned WORDS = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Environment memory (the thing the DUT talks to).
  logic [31:0] mem [WORDS];
  assign bus.mem_rdata = bus.mem_re ? mem[bus.mem_addr[AW+1:2]] : 32'h0;
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[AW+1:2]] <= bus.mem_wdata;

  // Reference model state.
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  logic [31:0] ref_mem [WORDS];
  wr_t         pend_q[$];
  logic        stg_valid;
  wr_t         stg;

  logic        exp_stall, exp_mis, exp_ill, exp_re, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic        chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("stall",      {31'h0, bus.stall},      {31'h0, exp_stall});
    chk("misaligned", {31'h0, bus.misaligned}, {31'h0, exp_mis});
    chk("illegal",    {31'h0, bus.illegal},    {31'h0, exp_ill});
    chk("mem_re",     {31'h0, bus.mem_re},     {31'h0, exp_re});
    chk("mem_we",     {31'h0, bus.mem_we},     {31'h0, exp_we});
    chk("mem_addr",   bus.mem_addr,  exp_addr);
    chk("mem_wdata",  bus.mem_wdata, exp_wdata);
    chk("rdata",      bus.rdata,     exp_rdata);
  end

  // Evaluate the expected outputs for the inputs now on the bus.
  task automatic model_eval();
    logic        ill, mis, sgn;
    int unsigned bytes, sh;
    logic [31:0] word, mask, val, a, wd;
    logic [2:0]  f3;
    exp_stall = 0; exp_mis = 0; exp_ill = 0; exp_re = 0; exp_we = 0;
    exp_addr = 0; exp_wdata = 0; exp_rdata = 0; stg_valid = 0;
    a  = bus.req_addr;
    wd = bus.req_wdata;
    f3 = bus.req_funct3;
    if (reset) return;
    if (pend_q.size() != 0) begin
      exp_we = 1; exp_addr = pend_q[0].a; exp_wdata = pend_q[0].d;
      return;
    end
    if (!bus.req_valid) return;
    ill   = bus.req_we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    bytes = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    mis   = (a % bytes) != 0;
    word  = ref_mem[(a / 4) % WORDS];
    mask  = (bytes == 1) ? 32'hFF : (bytes == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    sh    = (bytes == 1) ? (a % 4) * 8 : (bytes == 2) ? ((a / 2) % 2) * 16 : 0;
    if (ill) exp_ill = 1;
    else if (mis) exp_mis = 1;
    else if (!bus.req_we) begin
      exp_re = 1; exp_addr = a & ~32'h3;
      val = (word >> sh) & mask;
      sgn = (f3 == 3'd0 || f3 == 3'd1);
      if (sgn && (val & ((mask >> 1) + 1)) != 0) val = val | ~mask;
      exp_rdata = val;
    end else if (bytes == 4) begin
      exp_we = 1; exp_addr = a & ~32'h3; exp_wdata = wd;
    end else begin
      exp_re = 1; exp_stall = 1; exp_addr = a & ~32'h3;
      stg_valid = 1;
      stg.a = a & ~32'h3;
      stg.d = (word & ~(mask << sh)) | ((wd & mask) << sh);
    end
  endtask

  task automatic model_commit();
    if (reset) begin
      pend_q.delete();
    end else if (pend_q.size() != 0) begin
      ref_mem[(pend_q[0].a / 4) % WORDS] = pend_q[0].d;
      void'(pend_q.pop_front());
    end else if (exp_we) begin
      ref_mem[(exp_addr / 4) % WORDS] = exp_wdata;
    end else if (stg_valid) begin
      pend_q.push_back(stg);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    reset = rst; bus.req_valid = v; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    #0 model_eval();
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'h8899AABB;
    ref_mem[4] = 32'h8899AABB;
    bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_addr = 0; bus.req_wdata = 0;
    @(posedge clk); #1;
    chk_en = 1'b1;

    drive(1, 1, 0, 3'd2, 32'h10, 0);
    chk("reset_rdata", bus.rdata, 32'h0); step();
    drive(0, 0, 0, 3'd0, 32'h0, 0); step();

    drive(0, 1, 0, 3'd0, 32'h11, 0);
    chk("lb_lit", bus.rdata, 32'hFFFFFFAA); chk("lb_model", exp_rdata, 32'hFFFFFFAA); step();
    drive(0, 1, 0, 3'd4, 32'h11, 0);
    chk("lbu_lit", bus.rdata, 32'h000000AA); step();
    drive(0, 1, 0, 3'd1, 32'h12, 0);
    chk("lh_lit", bus.rdata, 32'hFFFF8899); chk("lh_model", exp_rdata, 32'hFFFF8899); step();
    drive(0, 1, 0, 3'd5, 32'h12, 0);
    chk("lhu_lit", bus.rdata, 32'h00008899); step();
    drive(0, 1, 0, 3'd2, 32'h10, 0);
    chk("lw_lit", bus.rdata, 32'h8899AABB); step();

    drive(0, 1, 1, 3'd0, 32'h13, 32'h123456CC);
    chk("sb_c1_stall", {31'h0, bus.stall}, 32'h1); step();
    drive(0, 1, 0, 3'd2, 32'h3C, $urandom);
    chk("sb_c2_wdata", bus.mem_wdata, 32'hCC99AABB); chk("sb_model", exp_wdata, 32'hCC99AABB); step();
    drive(0, 1, 0, 3'd2, 32'h10, 0);
    chk("sb_readback", bus.rdata, 32'hCC99AABB); step();

    drive(0, 1, 1, 3'd2, 32'h16, 32'hDEADBEEF);
    chk("sw_mis", {31'h0, bus.misaligned}, 32'h1); step();
    drive(0, 1, 1, 3'd4, 32'h10, 32'hDEADBEEF);
    chk("st_ill", {31'h0, bus.illegal}, 32'h1); chk("st_ill_mis", {31'h0, bus.misaligned}, 32'h0); step();

    drive(0, 1, 1, 3'd1, 32'h12, 32'h0000BEEF); step();
    drive(1, 1, 1, 3'd1, 32'h12, 32'h0000BEEF);
    chk("rst_in_write_we", {31'h0, bus.mem_we}, 32'h0); step();
    drive(0, 1, 0, 3'd2, 32'h10, 0);
    chk("after_rst_lw", bus.rdata, 32'hCC99AABB); step();

    drive(0, 1, 1, 3'd2, 32'h10, 32'h8899AABB); step();
    drive(0, 1, 1, 3'd1, 32'h10, 32'h00001111); step();
    drive(0, 0, 0, 3'd0, 32'h0, 0);
    chk("sh_drop_wdata", bus.mem_wdata, 32'h88991111); step();
    drive(0, 1, 0, 3'd2, 32'h10, 0);
    chk("sh_b2b_lw", bus.rdata, 32'h88991111); step();

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), $urandom_range(0, 1),
            3'($urandom_range(0, 7)), a, $urandom);
      step();
    end

    drive(0, 0, 0, 3'd0, 32'h0, 0); step();
    chk_en = 1'b0;
    for (int i = 0; i < WORDS; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
